// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with ready/valid output, redirect and halt
module fetch_unit #(
  parameter int PROG_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] PC,
  input  logic [7:0] Instruction,
  output logic [7:0] instr_out,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       jump_en,
  input  logic [7:0] jump_target,
  output logic       halted,
  output logic [7:0] fetch_count
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  localparam logic [8:0] PROG_END = 9'(PROG_LEN);

  state_t     state, state_n;
  logic [7:0] pc_n, instr_out_n, instr_pc_n, fetch_count_n;
  logic       instr_valid_n;
  logic       load;
  logic [8:0] pc_inc;

  assign load   = !instr_valid || instr_ready;
  assign pc_inc = {1'b0, PC} + 9'd1;
  assign halted = (state == HALT) && !instr_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      PC          <= 8'd0;
      instr_out   <= 8'd0;
      instr_pc    <= 8'd0;
      instr_valid <= 1'b0;
      fetch_count <= 8'd0;
    end else begin
      state       <= state_n;
      PC          <= pc_n;
      instr_out   <= instr_out_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      fetch_count <= fetch_count_n;
    end
  end

  // Redirect beats capture; a pending word is dropped even if accepted this cycle.
  always_comb begin
    state_n       = state;
    pc_n          = PC;
    instr_out_n   = instr_out;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    fetch_count_n = fetch_count;
    if (jump_en) begin
      pc_n          = jump_target;
      instr_valid_n = 1'b0;
      state_n       = ({1'b0, jump_target} < PROG_END) ? FETCH : HALT;
    end else if (state == FETCH && load) begin
      instr_out_n   = Instruction;
      instr_pc_n    = PC;
      instr_valid_n = 1'b1;
      pc_n          = pc_inc[7:0];
      fetch_count_n = (fetch_count == 8'hFF) ? 8'hFF : fetch_count + 8'd1;
      if (pc_inc == PROG_END) begin
        state_n = HALT;
      end
    end else if (state == HALT && load) begin
      instr_valid_n = 1'b0;
    end
  end

endmodule
